// File: rtl/clock_pkg.sv
// Shared clock-control types and default divisors for the CPU clock sequencer
// and any other block that derives timing from the board oscillator.
package clock_pkg;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        STEP  = 2'd3
    } seq_state_e;

    localparam logic [1:0] SPEED_SLOW = 2'd0;
    localparam logic [1:0] SPEED_MED  = 2'd1;
    localparam logic [1:0] SPEED_FAST = 2'd2;
    localparam logic [1:0] SPEED_MAX  = 2'd3;

    localparam int CNT_W_DEFAULT    = 28;
    localparam int DIV_SLOW_DEFAULT = 50_000_000;
    localparam int DIV_MED_DEFAULT  = 1_000_000;
    localparam int DIV_FAST_DEFAULT = 100_000;
    localparam int DIV_MAX_DEFAULT  = 2;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with a one-cycle pulse on
// each synchronized rising edge.
module sync_edge (
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic pulse
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_in};
            prev_q <= sync_q[1];
        end
    end

    assign level = sync_q[1];
    assign pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/cpu_clock_sequencer.sv
// 6502 system clock sequencer: free-run at a selectable rate, halt cleanly at a
// period boundary, or single-step one full period per button press.
//
// state | meaning
// HALT  | clock parked low, counter held at 0
// RUN   | free-running periods
// DRAIN | run released, finishing the current period
// STEP  | one full period, then back to HALT
module cpu_clock_sequencer
    import clock_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int DIV_SLOW = DIV_SLOW_DEFAULT,
    parameter int DIV_MED  = DIV_MED_DEFAULT,
    parameter int DIV_FAST = DIV_FAST_DEFAULT,
    parameter int DIV_MAX  = DIV_MAX_DEFAULT
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       run_req,
    input  logic       step_btn,
    input  logic [1:0] speed_sel,
    output logic       clk_out,
    output logic       cpu_tick,
    output logic       running,
    output logic       halted
);

    seq_state_e       state, state_nxt;
    logic [CNT_W-1:0] counter, counter_nxt;
    logic [CNT_W-1:0] div_act, div_nxt, div_sel, div_last;
    logic             run_lvl, run_rise, step_lvl, step_pulse;
    logic             wrap, period_start, clk_out_nxt;
    logic             unused_sync;

    sync_edge u_sync_run (
        .clk_in   (clk_in),
        .reset    (reset),
        .async_in (run_req),
        .level    (run_lvl),
        .pulse    (run_rise)
    );

    sync_edge u_sync_step (
        .clk_in   (clk_in),
        .reset    (reset),
        .async_in (step_btn),
        .level    (step_lvl),
        .pulse    (step_pulse)
    );

    assign unused_sync = run_rise ^ step_lvl;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= HALT;
        end else begin
            state <= state_nxt;
        end
    end

    assign div_last = div_act - CNT_W'(1);
    assign wrap     = (counter == div_last);

    // Run beats step when both arrive together; RUN skips DRAIN if released on the last cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            HALT: begin
                if (run_lvl) begin
                    state_nxt = RUN;
                end else if (step_pulse) begin
                    state_nxt = STEP;
                end
            end
            RUN: begin
                if (!run_lvl) begin
                    state_nxt = wrap ? HALT : DRAIN;
                end
            end
            DRAIN: begin
                if (run_lvl) begin
                    state_nxt = RUN;
                end else if (wrap) begin
                    state_nxt = HALT;
                end
            end
            STEP: begin
                if (wrap) begin
                    state_nxt = HALT;
                end
            end
            default: state_nxt = HALT;
        endcase
    end

    always_comb begin
        div_sel = CNT_W'(DIV_SLOW);
        unique case (speed_sel)
            SPEED_SLOW: div_sel = CNT_W'(DIV_SLOW);
            SPEED_MED:  div_sel = CNT_W'(DIV_MED);
            SPEED_FAST: div_sel = CNT_W'(DIV_FAST);
            SPEED_MAX:  div_sel = CNT_W'(DIV_MAX);
            default:    div_sel = CNT_W'(DIV_SLOW);
        endcase
    end

    // The divisor only changes where a new period begins, so no period is ever reshaped.
    always_comb begin
        period_start = (state_nxt != HALT) && ((state == HALT) || wrap);
        div_nxt      = period_start ? div_sel : div_act;
        counter_nxt  = ((state == HALT) || wrap) ? '0 : counter + CNT_W'(1);
        clk_out_nxt  = (state != HALT) && (counter < (div_act >> 1));
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            counter  <= '0;
            div_act  <= CNT_W'(DIV_SLOW);
            clk_out  <= 1'b0;
            cpu_tick <= 1'b0;
        end else begin
            counter  <= counter_nxt;
            div_act  <= div_nxt;
            clk_out  <= clk_out_nxt;
            cpu_tick <= clk_out_nxt & ~clk_out;
        end
    end

    always_comb begin
        running = (state == RUN) || (state == DRAIN);
        halted  = (state == HALT);
    end

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// Scenario bench for cpu_clock_sequencer; expected {clk_out, cpu_tick, running,
// halted} per cycle are queued up front and popped as each cycle is sampled.
module tb_cpu_clock_sequencer;

    logic       clk_in;
    logic       reset;
    logic       run_req;
    logic       step_btn;
    logic [1:0] speed_sel;
    logic       clk_out;
    logic       cpu_tick;
    logic       running;
    logic       halted;
    logic [3:0] obs_v;

    logic [3:0] sb[$];
    logic [3:0] exp_v;
    int         vectors;
    int         miscompares;
    int         n;

    cpu_clock_sequencer #(
        .CNT_W    (28),
        .DIV_SLOW (8),
        .DIV_MED  (6),
        .DIV_FAST (4),
        .DIV_MAX  (2)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .run_req   (run_req),
        .step_btn  (step_btn),
        .speed_sel (speed_sel),
        .clk_out   (clk_out),
        .cpu_tick  (cpu_tick),
        .running   (running),
        .halted    (halted)
    );

    assign obs_v = {clk_out, cpu_tick, running, halted};

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_n(input logic [3:0] v, input int cnt);
        for (int i = 0; i < cnt; i++) sb.push_back(v);
    endtask

    // Leaves the DUT in HALT at posedge+1 with reset just released.
    task automatic do_reset();
        reset    = 1'b1;
        run_req  = 1'b0;
        step_btn = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        run_req   = 1'b0;
        step_btn  = 1'b0;
        speed_sel = 2'd0;
        tick();
        tick();
        push_n(4'b0001, 51);
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == 1) reset = 1'b0;
            exp_v = sb.pop_front();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got %b expected %b", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_run_fast();
        do_reset();
        speed_sel = 2'd2;
        run_req   = 1'b1;
        push_n(4'b0001, 2);
        push_n(4'b0010, 1);
        for (int p = 0; p < 3; p++) begin
            push_n(4'b1110, 1);
            push_n(4'b1010, 1);
            push_n(4'b0010, 2);
        end
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            tick();
            exp_v = sb.pop_front();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL run_fast cyc %0d: got %b expected %b", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_speed_change();
        do_reset();
        speed_sel = 2'd0;
        run_req   = 1'b1;
        push_n(4'b0001, 2);
        push_n(4'b0010, 1);
        push_n(4'b1110, 1);
        push_n(4'b1010, 3);
        push_n(4'b0010, 4);
        for (int p = 0; p < 3; p++) begin
            push_n(4'b1110, 1);
            push_n(4'b0010, 1);
        end
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == 6) speed_sel = 2'd3;
            exp_v = sb.pop_front();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL speed_change cyc %0d: got %b expected %b", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_drain();
        do_reset();
        speed_sel = 2'd1;
        run_req   = 1'b1;
        push_n(4'b0001, 2);
        push_n(4'b0010, 1);
        push_n(4'b1110, 1);
        push_n(4'b1010, 2);
        push_n(4'b0010, 3);
        push_n(4'b1110, 1);
        push_n(4'b1010, 2);
        push_n(4'b0010, 2);
        push_n(4'b0001, 10);
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == 10) run_req = 1'b0;
            exp_v = sb.pop_front();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL drain cyc %0d: got %b expected %b", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_step();
        do_reset();
        speed_sel = 2'd2;
        step_btn  = 1'b1;
        push_n(4'b0001, 2);
        push_n(4'b0000, 1);
        push_n(4'b1100, 1);
        push_n(4'b1000, 1);
        push_n(4'b0000, 1);
        push_n(4'b0001, 11);
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == 2)  step_btn = 1'b0;
            if (k == 4)  step_btn = 1'b1;
            if (k == 10) step_btn = 1'b0;
            exp_v = sb.pop_front();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL step cyc %0d: got %b expected %b", k, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        speed_sel = 2'd3;
        run_req   = 1'b1;
        step_btn  = 1'b1;
        push_n(4'b0001, 2);
        push_n(4'b0010, 1);
        for (int p = 0; p < 3; p++) begin
            push_n(4'b1110, 1);
            push_n(4'b0010, 1);
        end
        push_n(4'b1110, 1);
        push_n(4'b0001, 2);
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == 10) begin
                reset    = 1'b1;
                run_req  = 1'b0;
                step_btn = 1'b0;
            end
            exp_v = sb.pop_front();
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL run_step_reset cyc %0d: got %b expected %b", k, obs_v, exp_v);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        run_req     = 1'b0;
        step_btn    = 1'b0;
        speed_sel   = 2'd0;
        test_reset();
        test_run_fast();
        test_speed_change();
        test_drain();
        test_step();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
